stch2dec_window: RTL and testbench
==================================

# stch2dec_window

Windowed stochastic-to-decimal converter. Counts the 1s on a stochastic bitstream over a fixed window of 2^WIN_LOG2 enabled samples and presents the scaled count as an ND-bit probability (x/2^ND). It sits directly downstream of the decimal-to-stochastic converter stage and the stochastic arithmetic fabric, and returns stream results to the decimal domain. A one-cycle VALID pulse marks each new result. D holds until the next window completes.

## Interface
- ND, 8: output precision in bits. D is scaled to x/2^ND.
- WIN_LOG2, 8: log2 of the window length in enabled samples. Must satisfy WIN_LOG2 >= ND.
- CLK  input  1  single clock; all state updates on the rising edge.
- INIT  input  1  reset, asynchronous, active-high.
- S  input  1  stochastic bit, sampled on the rising edge of CLK.
- EN  input  1  sample enable. When low, S is ignored and the window does not advance.
- START  input  1  begins a window from IDLE. Ignored in any other state.
- CONT  input  1  continuous mode, sampled at window end. 1 = start the next window immediately; 0 = return to IDLE.
- D  output  ND  result of the last completed window.
- VALID  output  1  single-cycle pulse; D was updated on this edge.
- BUSY  output  1  high while in RUN.

## Operation
- State: FSM {IDLE, RUN}.
  - Sample counter scnt: WIN_LOG2 bits.
  - Ones counter ocnt: WIN_LOG2+1 bits.
  - Output register D.
- Reset: INIT high asynchronously forces the following. It overrides every other input, including a reset asserted mid-window, which discards the partial count.
  - state = IDLE
  - scnt = 0, ocnt = 0
  - D = 0, VALID = 0, BUSY = 0
- IDLE:
  - With START = 1, go to RUN and clear scnt and ocnt. S is not sampled on this edge.
  - Otherwise hold. D keeps its last value.
- RUN, edge with EN = 1:
  - scnt increments. It is allowed to wrap 2^WIN_LOG2-1 -> 0.
  - ocnt increments by S.
- RUN, edge with EN = 0: scnt, ocnt, D and state all hold.
- Window end is an RUN edge with EN = 1 and scnt = 2^WIN_LOG2-1.
  - Compute total = ocnt + S (WIN_LOG2+1 bits).
  - D <= min(total >> (WIN_LOG2-ND), 2^ND-1). An all-ones window saturates to 2^ND-1 and never wraps to 0.
  - VALID <= 1 for exactly one cycle.
  - ocnt <= 0 and scnt <= 0.
  - If CONT = 1, stay in RUN. The next enabled sample belongs to the new window, with no dead cycle.
  - If CONT = 0, go to IDLE.
- START while in RUN is ignored. Mode changes take effect only at window end.
- BUSY = (state == RUN), registered.

## Timing
- If START is high at edge t0, BUSY is high from t0. Samples are taken at edges t0+1 through t0+2^WIN_LOG2, assuming EN stays high.
- D and VALID update at the edge of the final sample. VALID is high for exactly one cycle after that edge, then drops.
- In continuous mode with EN held high, VALID pulses every 2^WIN_LOG2 cycles.
- With EN low for k cycles inside a window, window latency is 2^WIN_LOG2 + k cycles.
- If EN is low on the would-be final edge, window end waits for the next EN = 1 edge.
- In IDLE, D holds its value indefinitely. Only INIT or a completed window changes D.

## Test plan
- Default parameters, START pulse, S = 1 and EN = 1 for 256 cycles, CONT = 0:
  - VALID on exactly the 256th sample edge.
  - D = 255 (saturated).
  - BUSY drops on that same edge; state returns to IDLE.
- S = 0 for a full window: D = 0, VALID pulses once.
- S alternating 1,0 for a full window: D = 128.
- S alternating 1,0 with WIN_LOG2 = 10: D = 128, window length 1024.
- CONT = 1, S = 1 for 3 windows then S = 0:
  - VALID pulses at cycles 256, 512, 768 after the first sample.
  - D = 255, 255, 255, then 0 after the fourth window.
  - BUSY stays high throughout, no gap between windows.
- EN toggling 1,0, S = 1:
  - Window completes after 511 cycles from the first sample; D = 255.
  - Spurious START pulses during RUN have no effect.
- INIT asserted asynchronously (between clock edges) mid-window after 100 samples:
  - D = 0, VALID = 0, BUSY = 0 immediately.
  - After a new START, the next D reflects only post-reset samples.

Source files
------------

// File: rtl/stch2dec_window.sv
// stch2dec_window: windowed stochastic-to-decimal converter.
// Counts the ones on S over windows of 2^WIN_LOG2 enabled samples. At each
// window end the scaled, saturated count is loaded into D (x/2^ND) and VALID
// pulses for one cycle. Requires WIN_LOG2 >= ND.
//
// Ports:
//   CLK    in   clock, rising edge
//   INIT   in   asynchronous active-high reset
//   S      in   stochastic bit
//   EN     in   sample enable; low holds the window
//   START  in   begin a window from IDLE
//   CONT   in   at window end: 1 = next window immediately, 0 = back to IDLE
//   D      out  ND-bit result of the last completed window
//   VALID  out  one-cycle pulse when D updates
//   BUSY   out  high while a window is running
module stch2dec_window #(
  parameter int unsigned ND       = 8,
  parameter int unsigned WIN_LOG2 = 8
) (
  input  logic          CLK,
  input  logic          INIT,
  input  logic          S,
  input  logic          EN,
  input  logic          START,
  input  logic          CONT,
  output logic [ND-1:0] D,
  output logic          VALID,
  output logic          BUSY
);

  localparam int unsigned CW    = WIN_LOG2 + 1;
  localparam int unsigned SHIFT = WIN_LOG2 - ND;
  localparam logic [WIN_LOG2-1:0] SCNT_LAST = '1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_nx;
  logic [WIN_LOG2-1:0] scnt, scnt_nx;
  logic [CW-1:0]       ocnt, ocnt_nx;
  logic [CW-1:0]       total, scaled;
  logic [ND-1:0]       d_sat, d_nx;
  logic                valid_nx;

  // Count including the current sample, scaled down to ND bits.
  assign total  = ocnt + CW'(S);
  assign scaled = total >> SHIFT;

  // An all-ones window scales to exactly 2^ND; clamp it to full scale.
  assign d_sat = (|scaled[CW-1:ND]) ? '1 : scaled[ND-1:0];

  // State and output registers.
  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      state <= IDLE;
      scnt  <= '0;
      ocnt  <= '0;
      D     <= '0;
      VALID <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      state <= state_nx;
      scnt  <= scnt_nx;
      ocnt  <= ocnt_nx;
      D     <= d_nx;
      VALID <= valid_nx;
      BUSY  <= (state_nx == RUN);
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_nx = state;
    scnt_nx  = scnt;
    ocnt_nx  = ocnt;
    d_nx     = D;
    valid_nx = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          state_nx = RUN;
          scnt_nx  = '0;
          ocnt_nx  = '0;
        end
      end
      RUN: begin
        if (EN) begin
          if (scnt == SCNT_LAST) begin
            d_nx     = d_sat;
            valid_nx = 1'b1;
            scnt_nx  = '0;
            ocnt_nx  = '0;
            if (!CONT) state_nx = IDLE;
          end else begin
            scnt_nx = scnt + WIN_LOG2'(1);
            ocnt_nx = total;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_stch2dec_window.sv
// Directed bench for stch2dec_window: one instance with the default window
// (256 samples) and one with a 1024-sample window, both ND = 8.
module tb_stch2dec_window;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       INIT;
  logic       s_a, en_a, start_a, cont_a;
  logic [7:0] d_a;
  logic       valid_a, busy_a;
  logic       s_b, en_b, start_b, cont_b;
  logic [7:0] d_b;
  logic       valid_b, busy_b;

  int errors = 0;
  int checks = 0;
  int cyc;
  bit gap;

  stch2dec_window #(.ND(8), .WIN_LOG2(8)) dut_a (
    .CLK(CLK), .INIT(INIT), .S(s_a), .EN(en_a), .START(start_a), .CONT(cont_a),
    .D(d_a), .VALID(valid_a), .BUSY(busy_a)
  );

  stch2dec_window #(.ND(8), .WIN_LOG2(10)) dut_b (
    .CLK(CLK), .INIT(INIT), .S(s_b), .EN(en_b), .START(start_b), .CONT(cont_b),
    .D(d_b), .VALID(valid_b), .BUSY(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive samples until VALID is seen. s_mode: 0 = all zeros, 1 = all ones,
  // 2 = alternating starting with 1. en_alt toggles EN 1,0,... ; poke_start
  // pulses START every 50 cycles. cyc = edges until VALID (-1 on timeout);
  // gap = BUSY was seen low before VALID.
  task automatic run_window(input bit use_b, input int s_mode, input bit en_alt,
                            input bit poke_start, input int budget,
                            output int cyc_o, output bit gap_o);
    logic sv, ev, st;
    cyc_o = -1;
    gap_o = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      ev = en_alt ? ((c % 2) == 1) : 1'b1;
      if (s_mode == 2) sv = ((c % 2) == 1);
      else             sv = (s_mode == 1);
      st = poke_start && ((c % 50) == 0);
      if (use_b) begin
        s_b = sv; en_b = ev;
      end else begin
        s_a = sv; en_a = ev; start_a = st;
      end
      tick();
      if (use_b ? valid_b : valid_a) begin
        cyc_o = c;
        break;
      end
      if (!(use_b ? busy_b : busy_a)) gap_o = 1'b1;
    end
    start_a = 1'b0;
    en_a    = 1'b0;
    en_b    = 1'b0;
  endtask

  initial begin
    INIT = 1'b1;
    s_a = 0; en_a = 0; start_a = 0; cont_a = 0;
    s_b = 0; en_b = 0; start_b = 0; cont_b = 0;
    tick();
    tick();
    chk("reset_d", 32'(d_a), 0);
    chk("reset_valid", 32'(valid_a), 0);
    chk("reset_busy", 32'(busy_a), 0);
    INIT = 1'b0;
    tick();

    // All-ones window, single shot: saturates to 255.
    start_a = 1'b1;
    tick();
    chk("t1_busy_at_start", 32'(busy_a), 1);
    start_a = 1'b0;
    run_window(1'b0, 1, 1'b0, 1'b0, 600, cyc, gap);
    chk("t1_valid_cycle", 32'(cyc), 256);
    chk("t1_d", 32'(d_a), 255);
    chk("t1_busy_drop", 32'(busy_a), 0);
    chk("t1_busy_gap", 32'(gap), 0);
    tick();
    chk("t1_valid_one_cycle", 32'(valid_a), 0);

    // IDLE holds D even with EN and S activity.
    s_a = 1'b0; en_a = 1'b1;
    repeat (5) tick();
    chk("idle_d_hold", 32'(d_a), 255);
    chk("idle_busy", 32'(busy_a), 0);
    chk("idle_valid", 32'(valid_a), 0);
    en_a = 1'b0;

    // All-zeros window.
    start_a = 1'b1; tick(); start_a = 1'b0;
    run_window(1'b0, 0, 1'b0, 1'b0, 600, cyc, gap);
    chk("t2_valid_cycle", 32'(cyc), 256);
    chk("t2_d", 32'(d_a), 0);
    tick();
    chk("t2_valid_drop", 32'(valid_a), 0);

    // Alternating window: 128 of 256.
    start_a = 1'b1; tick(); start_a = 1'b0;
    run_window(1'b0, 2, 1'b0, 1'b0, 600, cyc, gap);
    chk("t3_valid_cycle", 32'(cyc), 256);
    chk("t3_d", 32'(d_a), 128);

    // Alternating on a 1024-sample window: 512 >> 2 = 128.
    start_b = 1'b1; tick(); start_b = 1'b0;
    run_window(1'b1, 2, 1'b0, 1'b0, 1100, cyc, gap);
    chk("t4_valid_cycle", 32'(cyc), 1024);
    chk("t4_d", 32'(d_b), 128);
    chk("t4_busy_drop", 32'(busy_b), 0);

    // Continuous mode: three all-ones windows back to back, then zeros.
    cont_a = 1'b1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    for (int w = 0; w < 3; w++) begin
      run_window(1'b0, 1, 1'b0, 1'b0, 600, cyc, gap);
      chk($sformatf("t5_w%0d_cycle", w), 32'(cyc), 256);
      chk($sformatf("t5_w%0d_d", w), 32'(d_a), 255);
      chk($sformatf("t5_w%0d_busy", w), 32'(busy_a), 1);
      chk($sformatf("t5_w%0d_gap", w), 32'(gap), 0);
    end
    cont_a = 1'b0;
    run_window(1'b0, 0, 1'b0, 1'b0, 600, cyc, gap);
    chk("t5_w3_cycle", 32'(cyc), 256);
    chk("t5_w3_d", 32'(d_a), 0);
    chk("t5_w3_busy", 32'(busy_a), 0);

    // EN toggling with spurious START pulses: 256 samples over 511 edges.
    start_a = 1'b1; tick(); start_a = 1'b0;
    run_window(1'b0, 1, 1'b1, 1'b1, 1200, cyc, gap);
    chk("t6_valid_cycle", 32'(cyc), 511);
    chk("t6_d", 32'(d_a), 255);
    chk("t6_busy_gap", 32'(gap), 0);

    // Asynchronous INIT after 100 ones discards the partial count.
    start_a = 1'b1; tick(); start_a = 1'b0;
    s_a = 1'b1; en_a = 1'b1;
    repeat (100) tick();
    chk("t7_busy_before_init", 32'(busy_a), 1);
    #3 INIT = 1'b1;
    #1;
    chk("t7_init_d", 32'(d_a), 0);
    chk("t7_init_valid", 32'(valid_a), 0);
    chk("t7_init_busy", 32'(busy_a), 0);
    en_a = 1'b0; s_a = 1'b0;
    tick();
    INIT = 1'b0;
    tick();
    start_a = 1'b1; tick(); start_a = 1'b0;
    run_window(1'b0, 2, 1'b0, 1'b0, 600, cyc, gap);
    chk("t7_post_cycle", 32'(cyc), 256);
    chk("t7_post_d", 32'(d_a), 128);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
